tv80_regctl: RTL and testbench
==============================

# tv80_regctl

Register-port controller sitting directly upstream of the TV80 register file (8×16-bit, split H/L byte arrays, async read, write on `clk` when CEN). Translates logical pair selectors into physical register-file addresses, tracking the EXX alternate bank, the per-bank EX DE,HL swap and IX/IY selection. Also arbitrates byte writes and runs a two-cycle read-modify-write sequencer for 16-bit increment/decrement (INC/DEC rr, block-instruction BC/DE/HL updates).

## Interface
Parameters: none. Physical map (fixed): 0 BC, 1 DE, 2 HL, 3 IX, 4 BC', 5 DE', 6 HL', 7 IY. Logical pair codes: 0 BC, 1 DE, 2 HL, 3 XY.
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- cen  in  1  clock enable; all state and pulse inputs qualified by it
- sel_a, sel_b, sel_c  in  2  logical pair for ports A/B/C
- xy_sel  in  1  XY target: 0 IX, 1 IY
- exx  in  1  pulse: toggle alternate bank
- ex_dehl  in  1  pulse: toggle DE/HL swap flag of current bank
- wr_req  in  1  byte-write request (single cycle)
- wr_pair  in  2  logical pair to write
- wr_hi, wr_lo  in  1  write high / low byte enables
- wr_data  in  16  write data {H,L}
- id_req  in  1  level request for 16-bit inc/dec, held until accepted
- id_pair  in  2  logical pair for inc/dec
- id_dec  in  1  1 decrement, 0 increment
- doah, doal  in  8  register-file port A read data
- addr_a, addr_b, addr_c  out  3  register-file addresses
- dih, dil  out  8  register-file write data
- weh, wel  out  1  register-file write enables
- id_busy  out  1  sequencer in ID_RD or ID_WR
- id_done  out  1  high during the ID_WR cycle
- id_zero  out  1  result == 16'h0000, valid while id_done
- alt_bank  out  1  current bank
- wr_err  out  1  sticky: wr_req arrived while busy

## Operation
- Mapping, bank b = alt_bank, s = swap[b]: BC→4b; DE→(s?2:1)+4b; HL→(s?1:2)+4b; XY→(xy_sel?7:3), independent of bank/swap.
- addr_b, addr_c: always mapped sel_b/sel_c (combinational).
- Port A priority: ID_RD/ID_WR → latched id address; else wr_req → mapped wr_pair; else mapped sel_a.
- weh = cen & wr_req & wr_hi & IDLE, or cen & ID_WR; wel likewise with wr_lo. dih/dil = wr_data in IDLE, result in ID_WR.
- FSM IDLE→ID_RD when cen & id_req & !wr_req (latch mapped id_pair address and id_dec); ID_RD→ID_WR capturing {doah,doal}; ID_WR→IDLE writing captured±1 (modulo 2^16) to both bytes.
- wr_req with id_req in IDLE: write performed, id_req not accepted that cycle. wr_req during busy: ignored, wr_err set.
- exx and ex_dehl together: ex_dehl toggles the bank current before the exx toggle.
- Bank/swap changes during a sequence affect B/C mapping immediately; latched id address unchanged.

## Timing
- Reset: alt_bank=0, swap[0]=swap[1]=0, state IDLE, weh=wel=0, id_busy=id_done=id_zero=0, wr_err=0; addr_* reflect reset mapping.
- Byte write: zero latency, committed at the edge ending the wr_req cycle.
- Inc/dec: accept cycle T0, ID_RD T1, ID_WR T2 (commit at its closing edge); next request accepted earliest T3.
- cen low: state, flags and captured value frozen; weh=wel=0; pulses lost.
- Wrap: FFFF+1→0000 (id_zero=1); 0000−1→FFFF.
- reset_n low mid-sequence: immediate IDLE, no write.

## Structure
- Package tv80_regctl_pkg: pair codes, physical indices (IX=3, IY=7), FSM state enum.
- Sub-module tv80_regmap (combinational logical→physical), instantiated for ports A, B, C, write pair and id pair.

## Test plan
- Reset then sel_b=1 (DE) → addr_b=1; exx → addr_b=5; ex_dehl → addr_b=6; xy_sel=1, sel_b=3 → addr_b=7.
- wr_req pair HL, wr_hi only, data 16'h12AB → weh=1, wel=0, addr_a=2, dih=8'h12.
- HL=16'hFFFF, id_req inc → busy T1–T2, T2 addr_a=2, dih=dil=00, id_zero=1, id_done one cycle.
- BC=16'h0000, id_req dec → writes FFFF, id_zero=0; cen low for 3 cycles in ID_RD → completion delayed exactly 3 cycles.
- wr_req during ID_RD → no weh from wr_req, wr_err=1 until reset; reset_n pulse in ID_RD → IDLE, no write.
- exx and ex_dehl same cycle from reset → alt_bank=1, swap[0]=1, swap[1]=0; sel DE → addr 5.

Source files
------------

// File: rtl/tv80_regctl_pkg.sv
// tv80_regctl_pkg: pair codes, fixed physical indices and sequencer states
package tv80_regctl_pkg;
    typedef enum logic [1:0] {
        PAIR_BC = 2'd0,
        PAIR_DE = 2'd1,
        PAIR_HL = 2'd2,
        PAIR_XY = 2'd3
    } pair_e;

    localparam logic [2:0] PHYS_IX = 3'd3;
    localparam logic [2:0] PHYS_IY = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } state_e;
endpackage

// File: rtl/tv80_regmap.sv
// tv80_regmap: logical pair to physical register-file index
module tv80_regmap
    import tv80_regctl_pkg::*;
(
    input  logic [1:0] pair_i,
    input  logic       bank_i,
    input  logic       swap_i,
    input  logic       xy_sel_i,
    output logic [2:0] addr_o
);
    // BC/DE/HL live in the active bank; DE and HL trade places when swapped; XY ignores both
    always_comb addr_o = (pair_i == PAIR_BC) ? {bank_i, 2'b00} :
                         (pair_i == PAIR_DE) ? {bank_i, swap_i ? 2'b10 : 2'b01} :
                         (pair_i == PAIR_HL) ? {bank_i, swap_i ? 2'b01 : 2'b10} :
                         (xy_sel_i ? PHYS_IY : PHYS_IX);
endmodule

// File: rtl/tv80_regctl.sv
// tv80_regctl: register-file port control with bank/swap tracking and 16-bit inc/dec sequencer
module tv80_regctl
    import tv80_regctl_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cen_i,
    input  logic [1:0]  sel_a_i,
    input  logic [1:0]  sel_b_i,
    input  logic [1:0]  sel_c_i,
    input  logic        xy_sel_i,
    input  logic        exx_i,
    input  logic        ex_dehl_i,
    input  logic        wr_req_i,
    input  logic [1:0]  wr_pair_i,
    input  logic        wr_hi_i,
    input  logic        wr_lo_i,
    input  logic [15:0] wr_data_i,
    input  logic        id_req_i,
    input  logic [1:0]  id_pair_i,
    input  logic        id_dec_i,
    input  logic [7:0]  doah_i,
    input  logic [7:0]  doal_i,
    output logic [2:0]  addr_a_o,
    output logic [2:0]  addr_b_o,
    output logic [2:0]  addr_c_o,
    output logic [7:0]  dih_o,
    output logic [7:0]  dil_o,
    output logic        weh_o,
    output logic        wel_o,
    output logic        id_busy_o,
    output logic        id_done_o,
    output logic        id_zero_o,
    output logic        alt_bank_o,
    output logic        wr_err_o
);
    state_e      state_q;
    logic        alt_q;
    logic [1:0]  swap_q;
    logic [2:0]  id_addr_q;
    logic        id_dec_q;
    logic [15:0] cap_q;
    logic        wr_err_q;

    logic        swap_cur;
    logic [2:0]  map_a, map_wr, map_id;
    logic [15:0] res;
    logic        idle, in_wr;

    assign swap_cur = swap_q[alt_q];
    assign idle     = (state_q == ST_IDLE);
    assign in_wr    = (state_q == ST_WR);
    assign res      = id_dec_q ? cap_q - 16'd1 : cap_q + 16'd1;

    tv80_regmap u_map_a  (.pair_i(sel_a_i),   .bank_i(alt_q), .swap_i(swap_cur), .xy_sel_i(xy_sel_i), .addr_o(map_a));
    tv80_regmap u_map_b  (.pair_i(sel_b_i),   .bank_i(alt_q), .swap_i(swap_cur), .xy_sel_i(xy_sel_i), .addr_o(addr_b_o));
    tv80_regmap u_map_c  (.pair_i(sel_c_i),   .bank_i(alt_q), .swap_i(swap_cur), .xy_sel_i(xy_sel_i), .addr_o(addr_c_o));
    tv80_regmap u_map_wr (.pair_i(wr_pair_i), .bank_i(alt_q), .swap_i(swap_cur), .xy_sel_i(xy_sel_i), .addr_o(map_wr));
    tv80_regmap u_map_id (.pair_i(id_pair_i), .bank_i(alt_q), .swap_i(swap_cur), .xy_sel_i(xy_sel_i), .addr_o(map_id));

    // Port A belongs to the sequencer while busy, then to a pending byte write, then to sel_a
    always_comb begin
        addr_a_o = !idle ? id_addr_q : (wr_req_i ? map_wr : map_a);
        weh_o    = cen_i & ((idle & wr_req_i & wr_hi_i) | in_wr);
        wel_o    = cen_i & ((idle & wr_req_i & wr_lo_i) | in_wr);
        dih_o    = in_wr ? res[15:8] : wr_data_i[15:8];
        dil_o    = in_wr ? res[7:0]  : wr_data_i[7:0];
    end

    assign id_busy_o  = !idle;
    assign id_done_o  = in_wr;
    assign id_zero_o  = in_wr && (res == 16'h0000);
    assign alt_bank_o = alt_q;
    assign wr_err_o   = wr_err_q;

    // Bank/swap flags, sticky write error and the read-modify-write sequencer
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            alt_q     <= 1'b0;
            swap_q    <= 2'b00;
            id_addr_q <= 3'd0;
            id_dec_q  <= 1'b0;
            cap_q     <= 16'h0000;
            wr_err_q  <= 1'b0;
        end else if (cen_i) begin
            if (ex_dehl_i) swap_q[alt_q] <= ~swap_q[alt_q];
            if (exx_i) alt_q <= ~alt_q;
            if (wr_req_i && !idle) wr_err_q <= 1'b1;
            case (state_q)
                ST_IDLE: if (id_req_i && !wr_req_i) begin
                    state_q   <= ST_RD;
                    id_addr_q <= map_id;
                    id_dec_q  <= id_dec_i;
                end
                ST_RD: begin
                    cap_q   <= {doah_i, doal_i};
                    state_q <= ST_WR;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tv80_regctl.sv
// tb_tv80_regctl: randomized and directed checks of tv80_regctl against a behavioural model
module tb_tv80_regctl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cen = 1'b1;
    logic [1:0]  sel_a = '0, sel_b = '0, sel_c = '0;
    logic        xy_sel = 1'b0, exx = 1'b0, ex_dehl = 1'b0;
    logic        wr_req = 1'b0, wr_hi = 1'b0, wr_lo = 1'b0;
    logic [1:0]  wr_pair = '0;
    logic [15:0] wr_data = '0;
    logic        id_req = 1'b0, id_dec = 1'b0;
    logic [1:0]  id_pair = '0;
    logic [7:0]  doah, doal, dih, dil;
    logic [2:0]  addr_a, addr_b, addr_c;
    logic        weh, wel, id_busy, id_done, id_zero, alt_bank, wr_err;

    int total = 0;
    int bad = 0;

    logic [15:0] rf [8] = '{default: 16'h0000};
    logic [15:0] m_mem [8] = '{default: 16'h0000};
    logic        m_bank, m_err, m_dec;
    logic [1:0]  m_swap;
    int          m_ph;
    logic [2:0]  m_addr;
    logic [15:0] saved;

    always #5 clk = ~clk;

    tv80_regctl dut (
        .clk_i(clk), .rst_ni(rst_n), .cen_i(cen),
        .sel_a_i(sel_a), .sel_b_i(sel_b), .sel_c_i(sel_c), .xy_sel_i(xy_sel),
        .exx_i(exx), .ex_dehl_i(ex_dehl),
        .wr_req_i(wr_req), .wr_pair_i(wr_pair), .wr_hi_i(wr_hi), .wr_lo_i(wr_lo), .wr_data_i(wr_data),
        .id_req_i(id_req), .id_pair_i(id_pair), .id_dec_i(id_dec),
        .doah_i(doah), .doal_i(doal),
        .addr_a_o(addr_a), .addr_b_o(addr_b), .addr_c_o(addr_c),
        .dih_o(dih), .dil_o(dil), .weh_o(weh), .wel_o(wel),
        .id_busy_o(id_busy), .id_done_o(id_done), .id_zero_o(id_zero),
        .alt_bank_o(alt_bank), .wr_err_o(wr_err)
    );

    // Register file stand-in: async read on port A, byte writes on the clock
    assign doah = rf[addr_a][15:8];
    assign doal = rf[addr_a][7:0];
    always @(posedge clk) begin
        if (cen && weh) rf[addr_a][15:8] <= dih;
        if (cen && wel) rf[addr_a][7:0] <= dil;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        if (obs !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", tag, obs, want, $time);
        end
    endtask

    function automatic logic [2:0] phys(input logic [1:0] p);
        int base;
        logic s;
        base = m_bank ? 4 : 0;
        s = m_swap[m_bank];
        case (p)
            2'd0: return 3'(base);
            2'd1: return 3'(base + (s ? 2 : 1));
            2'd2: return 3'(base + (s ? 1 : 2));
            default: return xy_sel ? 3'd7 : 3'd3;
        endcase
    endfunction

    task automatic model_reset();
        m_bank = 1'b0; m_swap = 2'b00; m_err = 1'b0; m_ph = 0; m_dec = 1'b0; m_addr = 3'd0;
    endtask

    task automatic check_comb();
        logic [15:0] res;
        logic [2:0]  ea;
        logic        busy, done;
        busy = (m_ph != 0);
        done = (m_ph == 2);
        res  = m_dec ? m_mem[m_addr] - 16'd1 : m_mem[m_addr] + 16'd1;
        ea   = busy ? m_addr : (wr_req ? phys(wr_pair) : phys(sel_a));
        chk("addr_a", addr_a, ea);
        chk("addr_b", addr_b, phys(sel_b));
        chk("addr_c", addr_c, phys(sel_c));
        chk("weh", weh, cen && (done || (!busy && wr_req && wr_hi)));
        chk("wel", wel, cen && (done || (!busy && wr_req && wr_lo)));
        if (m_ph != 1) begin
            chk("dih", dih, done ? res[15:8] : wr_data[15:8]);
            chk("dil", dil, done ? res[7:0] : wr_data[7:0]);
        end
        chk("busy", id_busy, busy);
        chk("done", id_done, done);
        chk("zero", id_zero, done && res == 16'h0000);
        chk("alt", alt_bank, m_bank);
        chk("err", wr_err, m_err);
        chk("doa", {doah, doal}, m_mem[ea]);
    endtask

    task automatic model_step();
        logic [2:0] pa;
        if (!cen) return;
        if (m_ph == 0) begin
            if (wr_req) begin
                pa = phys(wr_pair);
                if (wr_hi) m_mem[pa][15:8] = wr_data[15:8];
                if (wr_lo) m_mem[pa][7:0] = wr_data[7:0];
            end else if (id_req) begin
                m_ph = 1; m_addr = phys(id_pair); m_dec = id_dec;
            end
        end else if (m_ph == 1) begin
            m_ph = 2;
            if (wr_req) m_err = 1'b1;
        end else begin
            m_mem[m_addr] = m_dec ? m_mem[m_addr] - 16'd1 : m_mem[m_addr] + 16'd1;
            m_ph = 0;
            if (wr_req) m_err = 1'b1;
        end
        if (ex_dehl) m_swap[m_bank] = ~m_swap[m_bank];
        if (exx) m_bank = ~m_bank;
    endtask

    task automatic step();
        #2;
        check_comb();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_comb();
        #1;
        rst_n = 1'b1;
    endtask

    task automatic bwrite(input logic [1:0] p, input logic [15:0] d);
        wr_req = 1'b1; wr_pair = p; wr_hi = 1'b1; wr_lo = 1'b1; wr_data = d;
        step();
        wr_req = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
    endtask

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        sel_b = 2'd1; #1; chk("plan_de", addr_b, 3'd1); step();
        exx = 1'b1; step(); exx = 1'b0; #1; chk("plan_exx", addr_b, 3'd5);
        ex_dehl = 1'b1; step(); ex_dehl = 1'b0; #1; chk("plan_swap", addr_b, 3'd6);
        xy_sel = 1'b1; sel_b = 2'd3; #1; chk("plan_iy", addr_b, 3'd7); step();
        xy_sel = 1'b0; sel_b = 2'd0;

        do_reset();
        wr_req = 1'b1; wr_pair = 2'd2; wr_hi = 1'b1; wr_lo = 1'b0; wr_data = 16'h12AB; #1;
        chk("plan_weh", weh, 1'b1); chk("plan_wel", wel, 1'b0);
        chk("plan_wa", addr_a, 3'd2); chk("plan_dih", dih, 8'h12);
        step();
        wr_req = 1'b0; wr_hi = 1'b0;

        bwrite(2'd2, 16'hFFFF);
        id_req = 1'b1; id_pair = 2'd2; id_dec = 1'b0; step(); id_req = 1'b0;
        #1; chk("inc_busy_t1", id_busy, 1'b1); chk("inc_done_t1", id_done, 1'b0);
        step();
        #1; chk("inc_done_t2", id_done, 1'b1); chk("inc_addr_t2", addr_a, 3'd2);
        chk("inc_di", {dih, dil}, 16'h0000); chk("inc_zero", id_zero, 1'b1);
        step();
        #1; chk("inc_done_t3", id_done, 1'b0); chk("inc_rf", rf[2], 16'h0000);

        bwrite(2'd0, 16'h0000);
        id_req = 1'b1; id_pair = 2'd0; id_dec = 1'b1; step(); id_req = 1'b0;
        cen = 1'b0;
        repeat (3) step();
        cen = 1'b1; #1; chk("dec_held", id_done, 1'b0);
        step();
        #1; chk("dec_done", id_done, 1'b1); chk("dec_di", {dih, dil}, 16'hFFFF); chk("dec_zero", id_zero, 1'b0);
        step();
        #1; chk("dec_rf", rf[0], 16'hFFFF);

        bwrite(2'd1, 16'h1000);
        id_req = 1'b1; id_pair = 2'd1; id_dec = 1'b0; step(); id_req = 1'b0;
        wr_req = 1'b1; wr_pair = 2'd1; wr_hi = 1'b1; wr_lo = 1'b1; wr_data = 16'h5555; #1;
        chk("busy_no_weh", weh, 1'b0);
        step();
        wr_req = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
        #1; chk("err_set", wr_err, 1'b1);
        step(); step();
        #1; chk("err_sticky", wr_err, 1'b1); chk("busy_rf", rf[1], 16'h1001);
        saved = rf[1];
        id_req = 1'b1; id_pair = 2'd1; step(); id_req = 1'b0;
        do_reset();
        #1; chk("rst_idle", id_busy, 1'b0); chk("rst_err", wr_err, 1'b0);
        repeat (3) step();
        chk("rst_nowrite", rf[1], saved);

        do_reset();
        exx = 1'b1; ex_dehl = 1'b1; step(); exx = 1'b0; ex_dehl = 1'b0;
        sel_b = 2'd1; #1; chk("both_alt", alt_bank, 1'b1); chk("both_de", addr_b, 3'd5);
        exx = 1'b1; step(); exx = 1'b0;
        #1; chk("swap0_de", addr_b, 3'd2);

        for (int i = 0; i < 4000; i++) begin
            cen     = ($urandom_range(0, 9) < 8);
            sel_a   = 2'($urandom); sel_b = 2'($urandom); sel_c = 2'($urandom);
            xy_sel  = 1'($urandom);
            exx     = ($urandom_range(0, 9) == 0);
            ex_dehl = ($urandom_range(0, 9) == 0);
            wr_req  = ($urandom_range(0, 4) == 0);
            wr_pair = 2'($urandom); wr_hi = 1'($urandom); wr_lo = 1'($urandom);
            wr_data = 16'($urandom);
            if ($urandom_range(0, 7) == 0) wr_data = 16'hFFFF;
            if ($urandom_range(0, 7) == 0) wr_data = 16'h0000;
            id_req  = ($urandom_range(0, 4) < 2);
            id_pair = 2'($urandom); id_dec = 1'($urandom);
            if ($urandom_range(0, 499) == 0) do_reset();
            step();
        end
        cen = 1'b1; wr_req = 1'b0; id_req = 1'b0; exx = 1'b0; ex_dehl = 1'b0;
        repeat (4) step();
        for (int i = 0; i < 8; i++) chk($sformatf("rf%0d", i), rf[i], m_mem[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
